video_output: RTL and testbench
===============================

VIDEO_OUTPUT -- requirements
Module: video_output

Interface
- REQ-001 Parameter WIDTH, default 400: active pixels per line.
- REQ-002 Parameter HEIGHT, default 512: active lines per frame.
- REQ-003 Parameter H_FRONT, default 16: horizontal front-porch cycles.
- REQ-004 Parameter H_SYNC, default 8: horizontal sync-region cycles.
- REQ-005 Parameter H_BACK, default 32: horizontal back-porch cycles.
- REQ-006 Parameter V_FRONT, default 4: vertical front-porch lines.
- REQ-007 Parameter V_SYNC, default 2: vertical sync-region lines.
- REQ-008 Parameter V_BACK, default 8: vertical back-porch lines.
- REQ-009 pixel_clock  input  1  sole clock; all logic on its rising edge.
- REQ-010 reset_n  input  1  asynchronous, active-low reset.
- REQ-011 pixel_rgb  input  24  generator colour for the pixel at x_pos/y_pos, valid the same cycle.
- REQ-012 x_pos  output  10  current horizontal count (combinational from the counter).
- REQ-013 y_pos  output  10  current vertical count.
- REQ-014 video_rgb  output  24  registered pixel to the scaler.
- REQ-015 video_de  output  1  registered data enable.
- REQ-016 video_hs  output  1  registered one-cycle horizontal sync pulse.
- REQ-017 video_vs  output  1  registered one-cycle vertical sync pulse.

Function
- REQ-018 The block SHALL keep h_count cycling 0..H_TOTAL-1, H_TOTAL = WIDTH+H_FRONT+H_SYNC+H_BACK (456 default), incrementing every cycle.
- REQ-019 On h_count = H_TOTAL-1, the block SHALL wrap h_count to 0 and advance v_count, which cycles 0..V_TOTAL-1, V_TOTAL = HEIGHT+V_FRONT+V_SYNC+V_BACK (526 default).
- REQ-020 Simultaneous last pixel and last line SHALL wrap both counters to 0 on the same edge.
- REQ-021 x_pos and y_pos SHALL equal h_count and v_count zero-extended to 10 bits; parameters giving H_TOTAL or V_TOTAL > 1024 are illegal.
- REQ-022 Active region is h_count < WIDTH and v_count < HEIGHT.
- REQ-023 Latency is exactly one cycle: at edge t+1, video_de SHALL equal active(t), and video_rgb SHALL equal pixel_rgb(t) if active(t), else 24'h0.
- REQ-024 video_hs SHALL be 1 for exactly one cycle, the cycle after h_count = WIDTH+H_FRONT, on every line including blanking lines.
- REQ-025 video_vs SHALL be 1 for exactly one cycle per frame: the cycle after h_count = WIDTH+H_FRONT with v_count = HEIGHT+V_FRONT, coincident with that line's video_hs.
- REQ-026 video_de SHALL never be 1 in a cycle where video_hs or video_vs is 1.
- REQ-027 pixel_rgb SHALL be ignored outside the active region.

Reset
- REQ-028 While reset_n = 0, the block SHALL asynchronously force h_count = 0, v_count = 0, video_rgb = 24'h0, video_de = 0, video_hs = 0, video_vs = 0.
- REQ-029 Counting SHALL resume from 0,0 on the first rising edge after reset_n deasserts.
- REQ-030 Reset asserted mid-line or mid-frame SHALL abort the current frame with no partial sync pulse emitted.

Configuration
- REQ-031 Macro VIDEO_OUTPUT_BORDER_EN defined: active pixels with h_count = 0, h_count = WIDTH-1, v_count = 0 or v_count = HEIGHT-1 SHALL output 24'hFFFFFF, overriding pixel_rgb; timing is unchanged.
- REQ-032 Macro VIDEO_OUTPUT_BORDER_EN undefined: no override logic SHALL be present; behaviour is per REQ-023.

Verification
- REQ-033 Reset scenario: release reset, hold pixel_rgb = 24'h123456 -> first edge gives de = 1 with rgb = 24'h123456, x_pos = 1 after that edge, and 400 consecutive de cycles per line.
- REQ-034 Line timing: run one line -> de falls after 400 cycles, hs is high exactly one cycle at output cycle 417 (counting from 1), and the line period is 456 cycles.
- REQ-035 Frame timing: run two frames -> vs is high once per 526×456 = 239856 cycles, coincident with hs on line 516, and de is never high with hs or vs.
- REQ-036 Blanking gating: pixel_rgb = 24'hFFFFFF constant -> video_rgb = 0 whenever de = 0.
- REQ-037 Mid-frame reset: reset_n pulsed low at v_count = 300, h_count = 200 -> all outputs 0 immediately, and the frame restarts at 0,0 with no vs before line 516.
- REQ-038 Border, with VIDEO_OUTPUT_BORDER_EN and pixel_rgb = 0 -> rgb = FFFFFF at x = 0 and 399 on all lines and across all of lines 0 and 511; interior pixels are 0.

Source files
------------

// File: rtl/video_output.sv
`default_nettype none
// video_output: raster timing generator; registers RGB/DE/HS/VS one cycle after pixel_rgb.
// Optional white one-pixel frame border enabled by defining VIDEO_OUTPUT_BORDER_EN.
module video_output #(
  parameter int WIDTH   = 400,
  parameter int HEIGHT  = 512,
  parameter int H_FRONT = 16,
  parameter int H_SYNC  = 8,
  parameter int H_BACK  = 32,
  parameter int V_FRONT = 4,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 8
) (
  input  logic        pixel_clock,
  input  logic        reset_n,
  input  logic [23:0] pixel_rgb,
  output logic [9:0]  x_pos,
  output logic [9:0]  y_pos,
  output logic [23:0] video_rgb,
  output logic        video_de,
  output logic        video_hs,
  output logic        video_vs
);

  localparam int H_TOTAL = WIDTH + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = HEIGHT + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT       = 10'(WIDTH);
  localparam logic [9:0] V_ACT       = 10'(HEIGHT);
  localparam logic [9:0] H_SYNC_POS  = 10'(WIDTH + H_FRONT);
  localparam logic [9:0] V_SYNC_LINE = 10'(HEIGHT + V_FRONT);

  logic [9:0]  h_count_q, h_count_d;
  logic [9:0]  v_count_q, v_count_d;
  logic [23:0] rgb_q, rgb_d;
  logic        de_q, de_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        active;

  assign active = (h_count_q < H_ACT) && (v_count_q < V_ACT);

`ifdef VIDEO_OUTPUT_BORDER_EN
  localparam logic [9:0] H_RIGHT  = 10'(WIDTH - 1);
  localparam logic [9:0] V_BOTTOM = 10'(HEIGHT - 1);
  logic on_border;
  assign on_border = (h_count_q == 10'd0) || (h_count_q == H_RIGHT) ||
                     (v_count_q == 10'd0) || (v_count_q == V_BOTTOM);
`endif

  always_comb begin
    h_count_d = h_count_q + 10'd1;
    v_count_d = v_count_q;
    if (h_count_q == H_LAST) begin
      h_count_d = 10'd0;
      v_count_d = (v_count_q == V_LAST) ? 10'd0 : v_count_q + 10'd1;
    end

    // Sync pulses are decoded from the current count, so they land one cycle later like the pixel data.
    de_d  = active;
    hs_d  = (h_count_q == H_SYNC_POS);
    vs_d  = hs_d && (v_count_q == V_SYNC_LINE);
    rgb_d = 24'h0;
    if (active) begin
`ifdef VIDEO_OUTPUT_BORDER_EN
      rgb_d = on_border ? 24'hFFFFFF : pixel_rgb;
`else
      rgb_d = pixel_rgb;
`endif
    end
  end

  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      h_count_q <= 10'd0;
      v_count_q <= 10'd0;
      rgb_q     <= 24'h0;
      de_q      <= 1'b0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
    end else begin
      h_count_q <= h_count_d;
      v_count_q <= v_count_d;
      rgb_q     <= rgb_d;
      de_q      <= de_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
    end
  end

  assign x_pos     = h_count_q;
  assign y_pos     = v_count_q;
  assign video_rgb = rgb_q;
  assign video_de  = de_q;
  assign video_hs  = hs_q;
  assign video_vs  = vs_q;

endmodule
`default_nettype wire

// File: tb/tb_video_output.sv
`default_nettype none
// Bench for video_output: a default-size instance and a small-raster instance, both checked
// every cycle against a raster-position model derived from the cycle count since reset.
module tb_video_output;

  localparam int DW = 400, DH = 512, DHF = 16, DHS = 8, DHB = 32, DVF = 4, DVS = 2, DVB = 8;
  localparam int SW = 20,  SH = 12,  SHF = 4,  SHS = 3, SHB = 5,  SVF = 2, SVS = 2, SVB = 3;
  localparam int SHT = SW + SHF + SHS + SHB;   // 32
  localparam int SVT = SH + SVF + SVS + SVB;   // 19
  localparam int SFRAME = SHT * SVT;           // 608

  logic        pixel_clock;
  logic        reset_n;
  logic [23:0] pixel_rgb;
  logic [23:0] cur;

  logic [9:0]  d_x, d_y, s_x, s_y;
  logic [23:0] d_rgb, s_rgb;
  logic        d_de, d_hs, d_vs, s_de, s_hs, s_vs;

  logic [46:0] a_d, a_s, e_d, e_s;
  assign a_d = {d_de, d_hs, d_vs, d_rgb, d_x, d_y};
  assign a_s = {s_de, s_hs, s_vs, s_rgb, s_x, s_y};

  int n_checks = 0;
  int n_fail   = 0;
  int p        = 0;

  video_output u_dflt (
    .pixel_clock(pixel_clock), .reset_n(reset_n), .pixel_rgb(pixel_rgb),
    .x_pos(d_x), .y_pos(d_y), .video_rgb(d_rgb),
    .video_de(d_de), .video_hs(d_hs), .video_vs(d_vs)
  );

  video_output #(
    .WIDTH(SW), .HEIGHT(SH), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
  ) u_small (
    .pixel_clock(pixel_clock), .reset_n(reset_n), .pixel_rgb(pixel_rgb),
    .x_pos(s_x), .y_pos(s_y), .video_rgb(s_rgb),
    .video_de(s_de), .video_hs(s_hs), .video_vs(s_vs)
  );

  initial pixel_clock = 1'b0;
  always #5 pixel_clock = ~pixel_clock;

  // Expected {de, hs, vs, rgb, x_pos, y_pos} after the edge that consumed raster position pos.
  function automatic logic [46:0] model(input int pos, input logic [23:0] rgb,
                                        input int w, input int h, input int hf, input int hs,
                                        input int hb, input int vf, input int vs, input int vb);
    int ht, vt, hc, vc;
    logic act, hsp, vsp, brd;
    logic [23:0] o;
    ht  = w + hf + hs + hb;
    vt  = h + vf + vs + vb;
    hc  = pos % ht;
    vc  = (pos / ht) % vt;
    act = (hc < w) && (vc < h);
    hsp = (hc == w + hf);
    vsp = hsp && (vc == h + vf);
    brd = (hc == 0) || (hc == w - 1) || (vc == 0) || (vc == h - 1);
`ifdef VIDEO_OUTPUT_BORDER_EN
    o = act ? (brd ? 24'hFFFFFF : rgb) : 24'h0;
`else
    o = act ? rgb : 24'h0;
    brd = 1'b0;
`endif
    return {act, hsp, vsp, o, 10'((pos + 1) % ht), 10'(((pos + 1) / ht) % vt)};
  endfunction

  task automatic tick(input logic [23:0] rgb);
    pixel_rgb = rgb;
    cur       = rgb;
    @(posedge pixel_clock);
    #1;
  endtask

  task automatic restart();
    reset_n = 1'b0;
    @(posedge pixel_clock);
    #1;
    reset_n = 1'b1;
    p = 0;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    pixel_rgb = 24'h0;
    repeat (3) @(posedge pixel_clock);
    #1;
    n_checks++;
    if (a_d !== 47'h0) begin
      n_fail++; $display("FAIL reset_dflt actual=%h expected=%h", a_d, 47'h0);
    end
    n_checks++;
    if (a_s !== 47'h0) begin
      n_fail++; $display("FAIL reset_small actual=%h expected=%h", a_s, 47'h0);
    end
    reset_n = 1'b1;
    p = 0;
    tick(24'h123456);
    n_checks++;
    if (a_d !== {1'b1, 1'b0, 1'b0, 24'h123456, 10'd1, 10'd0}) begin
      n_fail++; $display("FAIL first_edge actual=%h expected=%h", a_d,
                         {1'b1, 1'b0, 1'b0, 24'h123456, 10'd1, 10'd0});
    end
    p++;
  endtask

  task automatic test_line();
    int n_de, last_de, n_hs, hs_k;
    n_de = 0; last_de = 0; n_hs = 0; hs_k = 0;
    restart();
    for (int k = 1; k <= 456; k++) begin
      tick(24'($urandom));
      e_d = model(p, cur, DW, DH, DHF, DHS, DHB, DVF, DVS, DVB);
      n_checks++;
      if (a_d !== e_d) begin
        n_fail++; $display("FAIL line_dflt p=%0d actual=%h expected=%h", p, a_d, e_d);
      end
      if (d_de) begin n_de++; last_de = k; end
      if (d_hs) begin n_hs++; hs_k = k; end
      p++;
    end
    n_checks++;
    if (n_de !== 400 || last_de !== 400) begin
      n_fail++; $display("FAIL de_run count=%0d last=%0d expected 400/400", n_de, last_de);
    end
    n_checks++;
    if (n_hs !== 1 || hs_k !== 417) begin
      n_fail++; $display("FAIL hs_pos count=%0d cycle=%0d expected 1/417", n_hs, hs_k);
    end
    n_checks++;
    if (d_x !== 10'd0 || d_y !== 10'd1) begin
      n_fail++; $display("FAIL line_period x=%0d y=%0d expected 0/1", d_x, d_y);
    end
  endtask

  task automatic test_frame();
    int n_vs, prev_vs, bad_gap, overlap, vs_no_hs;
    n_vs = 0; prev_vs = -1; bad_gap = 0; overlap = 0; vs_no_hs = 0;
    for (int k = 0; k < 2 * SFRAME; k++) begin
      tick(24'($urandom));
      e_s = model(p, cur, SW, SH, SHF, SHS, SHB, SVF, SVS, SVB);
      n_checks++;
      if (a_s !== e_s) begin
        n_fail++; $display("FAIL frame_small p=%0d actual=%h expected=%h", p, a_s, e_s);
      end
      if (s_de && (s_hs || s_vs)) overlap++;
      if (d_de && (d_hs || d_vs)) overlap++;
      if (s_vs) begin
        if (!s_hs) vs_no_hs++;
        if (prev_vs >= 0 && (p - prev_vs) != SFRAME) bad_gap++;
        if (((p / SHT) % SVT) != SH + SVF) bad_gap++;
        prev_vs = p;
        n_vs++;
      end
      p++;
    end
    n_checks++;
    if (n_vs !== 2 || bad_gap !== 0) begin
      n_fail++; $display("FAIL vs_period count=%0d bad=%0d expected 2/0", n_vs, bad_gap);
    end
    n_checks++;
    if (overlap !== 0 || vs_no_hs !== 0) begin
      n_fail++; $display("FAIL sync_overlap de_overlap=%0d vs_without_hs=%0d expected 0/0",
                         overlap, vs_no_hs);
    end
  endtask

  task automatic test_blanking();
    for (int k = 0; k < SFRAME; k++) begin
      tick(24'hFFFFFF);
      if (!s_de) begin
        n_checks++;
        if (s_rgb !== 24'h0) begin
          n_fail++; $display("FAIL blank_small p=%0d actual=%h expected=000000", p, s_rgb);
        end
      end
      if (!d_de) begin
        n_checks++;
        if (d_rgb !== 24'h0) begin
          n_fail++; $display("FAIL blank_dflt p=%0d actual=%h expected=000000", p, d_rgb);
        end
      end
      p++;
    end
  endtask

  task automatic test_midframe_reset();
    bit found;
    int vs_p, n_vs;
    found = 1'b0; vs_p = -1; n_vs = 0;
    for (int k = 0; k < 2 * SFRAME && !found; k++) begin
      tick(24'($urandom));
      e_s = model(p, cur, SW, SH, SHF, SHS, SHB, SVF, SVS, SVB);
      n_checks++;
      if (a_s !== e_s) begin
        n_fail++; $display("FAIL pre_reset p=%0d actual=%h expected=%h", p, a_s, e_s);
      end
      p++;
      if (s_x == 10'd10 && s_y == 10'd6) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL reach_midframe x=%0d y=%0d expected 10/6", s_x, s_y);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (a_s !== 47'h0 || a_d !== 47'h0) begin
      n_fail++; $display("FAIL async_reset small=%h dflt=%h expected 0", a_s, a_d);
    end
    @(posedge pixel_clock);
    #1;
    reset_n = 1'b1;
    p = 0;
    for (int k = 0; k < SFRAME; k++) begin
      tick(24'($urandom));
      e_s = model(p, cur, SW, SH, SHF, SHS, SHB, SVF, SVS, SVB);
      e_d = model(p, cur, DW, DH, DHF, DHS, DHB, DVF, DVS, DVB);
      n_checks++;
      if (a_s !== e_s) begin
        n_fail++; $display("FAIL restart_small p=%0d actual=%h expected=%h", p, a_s, e_s);
      end
      n_checks++;
      if (a_d !== e_d) begin
        n_fail++; $display("FAIL restart_dflt p=%0d actual=%h expected=%h", p, a_d, e_d);
      end
      if (s_vs) begin n_vs++; if (vs_p < 0) vs_p = p; end
      p++;
    end
    n_checks++;
    if (n_vs !== 1 || vs_p !== (SH + SVF) * SHT + SW + SHF) begin
      n_fail++; $display("FAIL restart_vs count=%0d pos=%0d expected 1/%0d", n_vs, vs_p,
                         (SH + SVF) * SHT + SW + SHF);
    end
  endtask

  task automatic test_border();
    int n_white, exp_white;
`ifdef VIDEO_OUTPUT_BORDER_EN
    exp_white = 2 * SW + 2 * (SH - 2);
`else
    exp_white = 0;
`endif
    n_white = 0;
    restart();
    for (int k = 0; k < SFRAME; k++) begin
      tick(24'h0);
      e_s = model(p, cur, SW, SH, SHF, SHS, SHB, SVF, SVS, SVB);
      n_checks++;
      if (a_s !== e_s) begin
        n_fail++; $display("FAIL border_small p=%0d actual=%h expected=%h", p, a_s, e_s);
      end
      if (s_de && s_rgb == 24'hFFFFFF) n_white++;
      p++;
    end
    n_checks++;
    if (n_white !== exp_white) begin
      n_fail++; $display("FAIL border_count actual=%0d expected=%0d", n_white, exp_white);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    pixel_rgb = 24'h0;
    cur       = 24'h0;
    test_reset();
    test_line();
    test_frame();
    test_blanking();
    test_midframe_reset();
    test_border();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
